// File: rtl/klp_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | klp_mem_pkg                                                          |
// | Shared types and default sizing for the fetch/data memory arbiter.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package klp_mem_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MAX_DSTREAK = 4;
  localparam int DEF_TIMEOUT     = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } stateT;

  typedef enum logic [0:0] {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } ownerT;

endpackage : klp_mem_pkg
`default_nettype wire

// File: rtl/klp_rr_streak.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | klp_rr_streak                                                        |
// | Data-priority select with a bounded streak so fetch cannot starve.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module klp_rr_streak
  import klp_mem_pkg::*;
#(
  parameter int MAX_DSTREAK = DEF_MAX_DSTREAK
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ifReq,
  input  logic i_dReq,
  input  logic i_ifGnt,
  input  logic i_dGnt,
  output logic o_selData
);

  localparam int                c_streakW   = $clog2(MAX_DSTREAK + 1);
  localparam logic [c_streakW-1:0] c_maxStreak = c_streakW'(MAX_DSTREAK);

  logic [c_streakW-1:0] r_streak;
  logic [c_streakW-1:0] w_nextStreak;

  // Data wins unless fetch is waiting and data has used up its streak.
  assign o_selData = i_dReq && !(i_ifReq && (r_streak == c_maxStreak));

  always_comb begin
    w_nextStreak = r_streak;
    if (!i_ifReq || i_ifGnt) begin
      w_nextStreak = '0;
    end else if (i_dGnt && (r_streak != c_maxStreak)) begin
      w_nextStreak = r_streak + c_streakW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_streak <= '0;
    end else begin
      r_streak <= w_nextStreak;
    end
  end

endmodule : klp_rr_streak
`default_nettype wire

// File: rtl/klp_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | klp_mem_arbiter                                                      |
// | Two-requester (fetch/data) arbiter for a single-port memory with a   |
// | single outstanding transaction and a response timeout.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module klp_mem_arbiter
  import klp_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_DSTREAK = DEF_MAX_DSTREAK,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int                c_cntW    = $clog2(TIMEOUT + 1);
  localparam logic [c_cntW-1:0] c_cntLast = c_cntW'(TIMEOUT - 1);

  stateT             r_state;
  stateT             w_nextState;
  ownerT             r_owner;
  ownerT             w_nextOwner;
  logic [c_cntW-1:0] r_cnt;
  logic [c_cntW-1:0] w_nextCnt;

  logic w_selData;
  logic w_memReq;
  logic w_ifGnt;
  logic w_dGnt;
  logic w_respDone;
  logic w_ifRvalid;
  logic w_dRvalid;

  klp_rr_streak #(
    .MAX_DSTREAK (MAX_DSTREAK)
  ) u_streak (
    .clk       (clk),
    .reset     (reset),
    .i_ifReq   (if_req),
    .i_dReq    (d_req),
    .i_ifGnt   (if_gnt),
    .i_dGnt    (d_gnt),
    .o_selData (w_selData)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_owner <= OWN_IF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_owner <= w_nextOwner;
      r_cnt   <= w_nextCnt;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextOwner = r_owner;
    w_nextCnt   = r_cnt;
    w_memReq    = 1'b0;
    w_ifGnt     = 1'b0;
    w_dGnt      = 1'b0;
    w_respDone  = 1'b0;
    case (r_state)
      IDLE: begin
        w_memReq = if_req | d_req;
        if (w_memReq && mem_gnt) begin
          w_ifGnt     = !w_selData;
          w_dGnt      = w_selData;
          w_nextOwner = w_selData ? OWN_D : OWN_IF;
          w_nextCnt   = '0;
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        w_nextCnt = r_cnt + c_cntW'(1);
        // A real response beats a coincident timeout.
        w_respDone = mem_rvalid || (r_cnt == c_cntLast);
        if (w_respDone) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Handshake outputs are forced low while reset is held, independent of inputs.
  assign mem_req    = reset & w_memReq;
  assign if_gnt     = reset & w_ifGnt;
  assign d_gnt      = reset & w_dGnt;
  assign busy       = reset & (r_state == WAIT);

  assign w_ifRvalid = reset & w_respDone & (r_owner == OWN_IF);
  assign w_dRvalid  = reset & w_respDone & (r_owner == OWN_D);

  assign if_rvalid  = w_ifRvalid;
  assign if_err     = w_ifRvalid & !mem_rvalid;
  assign if_rdata   = (w_ifRvalid && mem_rvalid) ? mem_rdata : '0;

  assign d_rvalid   = w_dRvalid;
  assign d_err      = w_dRvalid & !mem_rvalid;
  assign d_rdata    = (w_dRvalid && mem_rvalid) ? mem_rdata : '0;

  assign mem_we     = w_selData & d_we;
  assign mem_addr   = w_selData ? d_addr  : if_addr;
  assign mem_wdata  = w_selData ? d_wdata : '0;
  assign mem_be     = w_selData ? d_be    : '1;

endmodule : klp_mem_arbiter
`default_nettype wire

// File: tb/tb_klp_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_klp_mem_arbiter                                                   |
// | Directed self-checking bench for klp_mem_arbiter (default params).   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_klp_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  klp_mem_arbiter u_dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .if_err     (if_err),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_be       (d_be),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are changed 1 time unit after the rising edge; checks follow 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] expD;

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset holds every handshake low even with live requests
    #2;
    if_req = 1'b1; d_req = 1'b1; mem_gnt = 1'b1;
    #1;
    checkVal("rst_if_gnt", if_gnt, 0);
    checkVal("rst_d_gnt", d_gnt, 0);
    checkVal("rst_mem_req", mem_req, 0);
    checkVal("rst_busy", busy, 0);
    tick(); tick();
    if_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b0;
    reset = 1'b1;
    tick();

    // Single fetch
    if_req = 1'b1; if_addr = 32'h10; mem_gnt = 1'b1;
    #2;
    checkVal("f_if_gnt", if_gnt, 1);
    checkVal("f_mem_req", mem_req, 1);
    checkVal("f_mem_addr", mem_addr, 32'h10);
    checkVal("f_mem_we", mem_we, 0);
    checkVal("f_mem_be", mem_be, 4'hF);
    checkVal("f_busy0", busy, 0);
    tick();
    if_req = 1'b0; mem_gnt = 1'b0;
    #2;
    checkVal("f_busy1", busy, 1);
    checkVal("f_mem_req_wait", mem_req, 0);
    checkVal("f_rvalid_early", if_rvalid, 0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h00500513;
    #2;
    checkVal("f_busy2", busy, 1);
    checkVal("f_if_rvalid", if_rvalid, 1);
    checkVal("f_if_rdata", if_rdata, 32'h00500513);
    checkVal("f_if_err", if_err, 0);
    checkVal("f_d_rvalid", d_rvalid, 0);
    checkVal("f_d_rdata", d_rdata, 0);
    tick();
    mem_rvalid = 1'b0;
    #2;
    checkVal("f_busy3", busy, 0);
    tick();

    // Simultaneous store and fetch: store first
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
    mem_gnt = 1'b1;
    #2;
    checkVal("s_d_gnt", d_gnt, 1);
    checkVal("s_if_gnt", if_gnt, 0);
    checkVal("s_mem_we", mem_we, 1);
    checkVal("s_mem_addr", mem_addr, 32'h100);
    checkVal("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
    checkVal("s_mem_be", mem_be, 4'hF);
    tick();
    d_req = 1'b0; d_we = 1'b0; mem_rvalid = 1'b1; mem_rdata = '0;
    #2;
    checkVal("s_d_rvalid", d_rvalid, 1);
    checkVal("s_if_rvalid", if_rvalid, 0);
    checkVal("s_if_gnt_wait", if_gnt, 0);
    tick();
    mem_rvalid = 1'b0;
    #2;
    checkVal("s_if_gnt_after", if_gnt, 1);
    checkVal("s_if_addr", mem_addr, 32'h20);
    checkVal("s_if_we", mem_we, 0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h13;
    #2;
    checkVal("s_if_rvalid2", if_rvalid, 1);
    checkVal("s_if_rdata2", if_rdata, 32'h13);
    tick();

    // Both held, 1-cycle memory: D,D,D,D,IF,D
    expD = 6'b101111;
    if_req = 1'b1; d_req = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55;
    for (int i = 0; i < 6; i++) begin
      #2;
      checkVal($sformatf("seq%0d_d_gnt", i), d_gnt, expD[i]);
      checkVal($sformatf("seq%0d_if_gnt", i), if_gnt, !expD[i]);
      checkVal($sformatf("seq%0d_idle_rv", i), {if_rvalid, d_rvalid}, 0);
      tick();
      #2;
      checkVal($sformatf("seq%0d_busy", i), busy, 1);
      checkVal($sformatf("seq%0d_d_rv", i), d_rvalid, expD[i]);
      checkVal($sformatf("seq%0d_if_rv", i), if_rvalid, !expD[i]);
      tick();
    end
    if_req = 1'b0; d_req = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
    tick();

    // Memory stalls for 3 cycles, then accepts
    d_req = 1'b1; d_addr = 32'h200;
    for (int i = 0; i < 3; i++) begin
      #2;
      checkVal($sformatf("stall%0d_d_gnt", i), d_gnt, 0);
      checkVal($sformatf("stall%0d_busy", i), busy, 0);
      checkVal($sformatf("stall%0d_mem_req", i), mem_req, 1);
      tick();
    end
    mem_gnt = 1'b1;
    #2;
    checkVal("stall_d_gnt", d_gnt, 1);
    tick();

    // No response: timeout on the 16th WAIT cycle
    d_req = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'hAAAA5555;
    for (int k = 1; k < 16; k++) begin
      #2;
      checkVal($sformatf("to%0d_d_rv", k), d_rvalid, 0);
      tick();
    end
    #2;
    checkVal("to_d_rvalid", d_rvalid, 1);
    checkVal("to_d_err", d_err, 1);
    checkVal("to_d_rdata", d_rdata, 0);
    tick();
    mem_rvalid = 1'b1;
    #2;
    checkVal("late_d_rvalid", d_rvalid, 0);
    checkVal("late_if_rvalid", if_rvalid, 0);
    checkVal("late_busy", busy, 0);
    tick();
    mem_rvalid = 1'b0;

    // Response coinciding with timeout wins
    if_req = 1'b1; if_addr = 32'h40; mem_gnt = 1'b1;
    #2;
    checkVal("co_if_gnt", if_gnt, 1);
    tick();
    if_req = 1'b0; mem_gnt = 1'b0;
    for (int k = 1; k < 16; k++) tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234;
    #2;
    checkVal("co_if_rvalid", if_rvalid, 1);
    checkVal("co_if_err", if_err, 0);
    checkVal("co_if_rdata", if_rdata, 32'h1234);
    tick();
    mem_rvalid = 1'b0;

    // Reset in WAIT abandons the transaction
    if_req = 1'b1; if_addr = 32'h80; mem_gnt = 1'b1;
    #2;
    checkVal("rw_if_gnt", if_gnt, 1);
    tick();
    if_req = 1'b0;
    #2;
    checkVal("rw_busy_pre", busy, 1);
    reset = 1'b0; mem_rvalid = 1'b1;
    #1;
    checkVal("rw_busy", busy, 0);
    checkVal("rw_if_rvalid", if_rvalid, 0);
    checkVal("rw_mem_req", mem_req, 0);
    tick();
    #1;
    reset = 1'b1;
    #1;
    checkVal("rw_late_rv", if_rvalid, 0);
    checkVal("rw_late_busy", busy, 0);
    tick();
    mem_rvalid = 1'b0; if_req = 1'b1;
    #2;
    checkVal("rw_if_gnt_after", if_gnt, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule : tb_klp_mem_arbiter
`default_nettype wire
